// File: rtl/tone_gen.sv
// tone_gen: Avalon-MM beeper driver. It supports a manual level mode, a continuous
// square-wave tone, and counted tone bursts with a sticky DONE flag and a level irq.
module tone_gen #(
    parameter int   CNT_W      = 24,
    parameter int   DUR_W      = 16,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_port,
    output logic        irq
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PH_A = 2'd1,
        S_PH_B = 2'd2
    } state_t;

    localparam logic [1:0] A_CTRL     = 2'd0;
    localparam logic [1:0] A_HALF     = 2'd1;
    localparam logic [1:0] A_DUR      = 2'd2;
    localparam logic [1:0] A_CMD      = 2'd3;
    localparam logic [1:0] MODE_CONT  = 2'd1;
    localparam logic [1:0] MODE_BURST = 2'd2;

    state_t           state, state_nxt;
    logic             level, level_nxt;
    logic [1:0]       mode, mode_nxt;
    logic             irq_en, irq_en_nxt;
    logic [CNT_W-1:0] half;
    logic [DUR_W-1:0] dur;
    logic             done, done_nxt, done_set;
    logic [CNT_W-1:0] half_cnt, half_cnt_nxt;
    logic [DUR_W-1:0] rem, rem_nxt;
    logic             out_nxt;

    logic wr, wr_ctrl, wr_half, wr_dur, wr_cmd;
    logic start_cmd, clr_cmd, abort, launch;

    assign wr        = chipselect & ~write_n;
    assign wr_ctrl   = wr && (address == A_CTRL);
    assign wr_half   = wr && (address == A_HALF);
    assign wr_dur    = wr && (address == A_DUR);
    assign wr_cmd    = wr && (address == A_CMD);
    assign start_cmd = wr_cmd & writedata[0];
    assign clr_cmd   = wr_cmd & writedata[1];

    assign level_nxt  = wr_ctrl ? writedata[0]   : level;
    assign mode_nxt   = wr_ctrl ? writedata[2:1] : mode;
    assign irq_en_nxt = wr_ctrl ? writedata[3]   : irq_en;

    // A running tone only ever has mode 1 or 2; any CTRL write that changes it stops the tone.
    assign abort = wr_ctrl && (writedata[2:1] != mode);

    logic unused_wdata;
    assign unused_wdata = &{1'b0, writedata[31:CNT_W]};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt    = state;
        half_cnt_nxt = half_cnt;
        rem_nxt      = rem;
        done_set     = 1'b0;
        launch       = 1'b0;

        if (state == S_IDLE) begin
            if (mode_nxt == MODE_CONT) begin
                launch = 1'b1;
            end else if (start_cmd && mode == MODE_BURST) begin
                if (dur == '0) done_set = 1'b1;
                else           launch   = 1'b1;
            end
        end else if (abort) begin
            state_nxt = S_IDLE;
        end else if (start_cmd && mode == MODE_BURST) begin
            if (dur == '0) begin
                state_nxt = S_IDLE;
                done_set  = 1'b1;
            end else begin
                launch = 1'b1;
            end
        end else if (half_cnt == '0) begin
            half_cnt_nxt = half;
            if (state == S_PH_A) begin
                state_nxt = S_PH_B;
            end else if (mode == MODE_BURST && rem == DUR_W'(1)) begin
                state_nxt = S_IDLE;
                done_set  = 1'b1;
            end else begin
                state_nxt = S_PH_A;
                if (mode == MODE_BURST) rem_nxt = rem - DUR_W'(1);
            end
        end else begin
            half_cnt_nxt = half_cnt - CNT_W'(1);
        end

        if (launch) begin
            state_nxt    = S_PH_A;
            half_cnt_nxt = half;
            rem_nxt      = dur;
        end
    end

    // A completion in the same cycle as CLR_DONE leaves DONE set.
    assign done_nxt = done_set | (done & ~clr_cmd);

    always_comb begin
        out_nxt = level_nxt;
        case (state_nxt)
            S_PH_A:  out_nxt = ~IDLE_LEVEL;
            S_PH_B:  out_nxt = IDLE_LEVEL;
            default: out_nxt = level_nxt;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            level    <= IDLE_LEVEL;
            mode     <= '0;
            irq_en   <= 1'b0;
            half     <= '0;
            dur      <= '0;
            done     <= 1'b0;
            half_cnt <= '0;
            rem      <= '0;
            out_port <= IDLE_LEVEL;
            irq      <= 1'b0;
        end else begin
            state    <= state_nxt;
            level    <= level_nxt;
            mode     <= mode_nxt;
            irq_en   <= irq_en_nxt;
            if (wr_half) half <= writedata[CNT_W-1:0];
            if (wr_dur)  dur  <= writedata[DUR_W-1:0];
            done     <= done_nxt;
            half_cnt <= half_cnt_nxt;
            rem      <= rem_nxt;
            out_port <= out_nxt;
            irq      <= done_nxt & irq_en_nxt;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            A_CTRL: readdata[3:0]       = {irq_en, mode, level};
            A_HALF: readdata[CNT_W-1:0] = half;
            A_DUR:  readdata[DUR_W-1:0] = dur;
            default: readdata[1:0]      = {done, state != S_IDLE};
        endcase
    end
endmodule

// File: tb/tb_tone_gen.sv
// Scoreboarded random test for tone_gen: the driver advances a time-based model and queues
// the expected outputs, and a negedge monitor compares them with out_port, irq and readdata.
module tb_tone_gen;
    localparam logic IDLE = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_port;
    logic        irq;

    tone_gen dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        out;
        logic        irq;
        logic [1:0]  addr;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: a tone is a run of phases, each lasting HALF+1 edges from its start;
    // a burst is 2*DUR phases.
    int          cyc = 0;
    logic        m_level, m_irq_en, m_done;
    logic [1:0]  m_mode;
    logic [23:0] m_half;
    logic [15:0] m_dur;
    logic        m_run, m_phase_b;
    int          m_phase_end, m_left;

    task automatic model_reset();
        m_level = IDLE; m_mode = 2'd0; m_irq_en = 1'b0; m_half = '0; m_dur = '0;
        m_done = 1'b0; m_run = 1'b0; m_phase_b = 1'b0; m_phase_end = 0; m_left = 0;
    endtask

    task automatic begin_tone();
        m_run = 1'b1;
        m_phase_b = 1'b0;
        m_phase_end = cyc + int'(m_half) + 1;
        m_left = 2 * int'(m_dur);
    endtask

    task automatic model_step(input logic wr, input logic [1:0] a, input logic [31:0] d);
        logic       ctrl_w, start, clr, set_done;
        logic [1:0] nm;
        ctrl_w = wr && a == 2'd0;
        start  = wr && a == 2'd3 && d[0];
        clr    = wr && a == 2'd3 && d[1];
        nm     = ctrl_w ? d[2:1] : m_mode;
        set_done = 1'b0;
        if (m_run && ctrl_w && nm != m_mode) begin
            m_run = 1'b0;
        end else if (start && m_mode == 2'd2) begin
            if (m_dur == 0) begin
                m_run = 1'b0;
                set_done = 1'b1;
            end else begin
                begin_tone();
            end
        end else if (m_run) begin
            if (cyc == m_phase_end) begin
                m_left--;
                if (m_mode == 2'd2 && m_left == 0) begin
                    m_run = 1'b0;
                    set_done = 1'b1;
                end else begin
                    m_phase_b = ~m_phase_b;
                    m_phase_end = cyc + int'(m_half) + 1;
                end
            end
        end else if (nm == 2'd1) begin
            begin_tone();
        end
        if (ctrl_w) begin
            m_level = d[0]; m_mode = d[2:1]; m_irq_en = d[3];
        end
        if (wr && a == 2'd1) m_half = d[23:0];
        if (wr && a == 2'd2) m_dur  = d[15:0];
        m_done = set_done | (m_done & ~clr);
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_irq_en, m_mode, m_level};
            2'd1:    return {8'd0, m_half};
            2'd2:    return {16'd0, m_dur};
            default: return {30'd0, m_done, m_run};
        endcase
    endfunction

    // One bus cycle: apply inputs, queue what the DUT must show during this cycle, then step.
    task automatic drive(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] d);
        exp_t e;
        chipselect = cs; write_n = wn; address = a; writedata = d;
        e.out  = m_run ? (m_phase_b ? IDLE : ~IDLE) : m_level;
        e.irq  = m_done & m_irq_en;
        e.addr = a;
        e.rd   = model_rd(a);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        if (reset) model_reset();
        else       model_step(cs & ~wn, a, d);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)), $urandom());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        idle(2);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (out_port !== e.out) begin
                n_err++;
                $display("FAIL out_port t=%0t got %0b exp %0b", $time, out_port, e.out);
            end
            if (irq !== e.irq) begin
                n_err++;
                $display("FAIL irq t=%0t got %0b exp %0b", $time, irq, e.irq);
            end
            if (readdata !== e.rd) begin
                n_err++;
                $display("FAIL readdata[%0d] t=%0t got %h exp %h", e.addr, $time, readdata, e.rd);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        model_reset();
        @(posedge clk);
        #1;
        idle(2);
        reset = 1'b0;
        idle(2);

        // manual level
        wr(0, 32'h0); idle(2); wr(0, 32'h1); idle(2);
        // burst with irq, then clear
        wr(1, 2); wr(2, 3); wr(0, 32'hC); wr(3, 1); idle(22); wr(3, 2); idle(3);
        // continuous, HALF change mid-run, exit via MODE 0 with LEVEL=1
        wr(1, 0); wr(0, 32'h2); idle(6); wr(1, 4); idle(25); wr(0, 32'h1); idle(3);
        // DUR=0 start
        wr(2, 0); wr(0, 32'hC); wr(3, 1); idle(3); wr(3, 2); idle(2);
        // start exactly at the completion edge
        wr(1, 0); wr(2, 2); wr(3, 1); idle(3); wr(3, 1); idle(10);
        // CLR_DONE coincident with completion
        wr(3, 2); wr(3, 1); idle(3); wr(3, 2); idle(4); wr(3, 2);
        // restart mid-burst, then START in MODE 0
        wr(1, 3); wr(2, 2); wr(3, 1); idle(5); wr(3, 1); idle(20);
        wr(0, 32'h0); wr(3, 1); idle(3);
        // reset mid-burst
        wr(0, 32'h4); wr(1, 5); wr(2, 5); wr(3, 1); idle(7); do_reset(); idle(3);

        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 2)        do_reset();
            else if (r < 40)  wr(0, $urandom());
            else if (r < 90)  wr(1, ($urandom() & 32'hFF00_0000) | $urandom_range(0, 5));
            else if (r < 130) wr(2, ($urandom() & 32'hFFFF_0000) | $urandom_range(0, 4));
            else if (r < 175) wr(3, ($urandom() & 32'hFFFF_FFFC) | $urandom_range(0, 3));
            else if (r < 200) drive(1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom());
            else              idle(1);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left %0d exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
